// File: rtl/button_step.sv
// rtl/button_step.sv - two-button synchroniser/debouncer producing clean step pulses
//
// Purpose:
//   Turns the raw up/down push-button levels into single-cycle step pulses
//   for the decimal digit counter chain. Each channel is synchronised,
//   debounced and edge-detected. A press that lands while the other
//   button is already (debounced) held is ignored.
//
// Optional feature:
//   BUTTON_REPEAT_EN - when defined, a held and unlocked button auto-repeats:
//   first repeat p_repeat_delay cycles after the press pulse, then every
//   p_repeat_period cycles. When undefined, exactly one pulse per press.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_btn_inc  raw "up" button level (asynchronous)
//   i_btn_dec  raw "down" button level (asynchronous)
//   o_inc      one-cycle step-up pulse (registered)
//   o_dec      one-cycle step-down pulse (registered)
//   o_held     debounced levels (registered), bit0 = inc, bit1 = dec
module button_step #(
  parameter int p_sync          = 2,
  parameter int p_debounce      = 16,
  parameter int p_repeat_delay  = 50000,
  parameter int p_repeat_period = 10000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_inc,
  input  logic       i_btn_dec,
  output logic       o_inc,
  output logic       o_dec,
  output logic [1:0] o_held
);

  localparam int DW = $clog2(p_debounce + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(p_debounce - 1);

  if (p_sync < 2 || p_debounce < 1 || p_repeat_delay < 1 || p_repeat_period < 1) begin : g_param_check
    $error("button_step: illegal parameter value");
  end

  // Channel index 0 = inc, 1 = dec throughout.
  logic [1:0]        raw;
  logic [p_sync-1:0] sync_q [2];
  logic [DW-1:0]     db_cnt [2];
  logic [1:0]        sync_lvl;
  logic [1:0]        deb_q;      // debounced level
  logic [1:0]        deb_d;      // debounced level one cycle ago, for rise detection
  logic [1:0]        deb_swap;   // the *other* channel's debounced level
  logic [1:0]        rise;
  logic [1:0]        press_ok;   // rising edge that is not locked out
  logic [1:0]        step;
  logic [1:0]        pulse_q;

  assign raw      = {i_btn_dec, i_btn_inc};
  assign deb_swap = {deb_q[0], deb_q[1]};
  assign rise     = deb_q & ~deb_d;
  // A simultaneous rise sees the other level already high, so both lock.
  assign press_ok = rise & ~deb_swap;

  always_comb begin
    sync_lvl = '0;
    for (int ch = 0; ch < 2; ch++) begin
      sync_lvl[ch] = sync_q[ch][p_sync-1];
    end
  end

`ifdef BUTTON_REPEAT_EN
  localparam int REP_MAX = (p_repeat_delay > p_repeat_period) ? p_repeat_delay : p_repeat_period;
  localparam int RW = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] REP_DELAY  = RW'(p_repeat_delay);
  localparam logic [RW-1:0] REP_PERIOD = RW'(p_repeat_period);

  // rep_cnt == 0 means the timer is idle; it is loaded with 1 on the press
  // pulse so that a count equal to the target lands exactly on the target cycle.
  logic [RW-1:0] rep_cnt [2];
  logic [1:0]    rep_first;
  logic [1:0]    rep_run;
  logic [1:0]    rep_fire;

  always_comb begin
    rep_run  = '0;
    rep_fire = '0;
    for (int ch = 0; ch < 2; ch++) begin
      // The other button going down counts as lockout: the timer dies.
      rep_run[ch]  = (rep_cnt[ch] != '0) && deb_q[ch] && !deb_swap[ch];
      rep_fire[ch] = rep_run[ch] &&
                     (rep_cnt[ch] == (rep_first[ch] ? REP_DELAY : REP_PERIOD));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        rep_cnt[ch] <= '0;
      end
      rep_first <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (press_ok[ch]) begin
          rep_cnt[ch]   <= RW'(1);
          rep_first[ch] <= 1'b1;
        end else if (!rep_run[ch]) begin
          rep_cnt[ch]   <= '0;
        end else if (rep_fire[ch]) begin
          rep_cnt[ch]   <= RW'(1);
          rep_first[ch] <= 1'b0;
        end else begin
          rep_cnt[ch]   <= rep_cnt[ch] + RW'(1);
        end
      end
    end
  end

  assign step = press_ok | rep_fire;
`else
  assign step = press_ok;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        sync_q[ch] <= '0;
        db_cnt[ch] <= '0;
      end
      deb_q   <= '0;
      deb_d   <= '0;
      pulse_q <= '0;
    end else begin
      deb_d   <= deb_q;
      pulse_q <= step;
      for (int ch = 0; ch < 2; ch++) begin
        sync_q[ch] <= {sync_q[ch][p_sync-2:0], raw[ch]};
        // Level must disagree for p_debounce consecutive cycles before it
        // is accepted; any agreement restarts the count.
        if (sync_lvl[ch] == deb_q[ch]) begin
          db_cnt[ch] <= '0;
        end else if (db_cnt[ch] == DB_LAST) begin
          deb_q[ch]  <= ~deb_q[ch];
          db_cnt[ch] <= '0;
        end else begin
          db_cnt[ch] <= db_cnt[ch] + DW'(1);
        end
      end
    end
  end

  assign o_inc  = pulse_q[0];
  assign o_dec  = pulse_q[1];
  assign o_held = deb_q;

endmodule

// File: tb/tb_button_step.sv
// tb/tb_button_step.sv - scoreboard bench for button_step
module tb_button_step;

  localparam int P_SYNC = 2;
  localparam int P_DEB  = 4;
  localparam int P_RD   = 20;
  localparam int P_RP   = 5;
  localparam int LAT    = P_SYNC + P_DEB + 1;  // drive at negedge after edge c -> pulse after edge c+LAT

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_btn_inc = 1'b0;
  logic       i_btn_dec = 1'b0;
  logic       o_inc;
  logic       o_dec;
  logic [1:0] o_held;

  button_step #(
    .p_sync(P_SYNC),
    .p_debounce(P_DEB),
    .p_repeat_delay(P_RD),
    .p_repeat_period(P_RP)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_btn_inc(i_btn_inc),
    .i_btn_dec(i_btn_dec),
    .o_inc(o_inc),
    .o_dec(o_dec),
    .o_held(o_held)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic ch;   // 0 = inc, 1 = dec
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic push(input int c, input logic ch);
    exp_t e;
    e.cyc = c;
    e.ch  = ch;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Pulse monitor: every observed pulse must match the head of the scoreboard.
  always @(negedge i_clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL pulse_missed ch=%0d actual=none required_edge=%0d", sb[0].ch, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (!i_rst && (o_inc || o_dec)) begin
      checks++;
      if (o_inc && o_dec) begin
        failures++;
        $display("FAIL exclusive edge=%0d actual=inc&dec required=one", cyc);
      end else if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse edge=%0d actual_ch=%0d required=none", cyc, o_dec);
      end else begin
        e = sb.pop_front();
        if (e.cyc !== cyc || e.ch !== o_dec) begin
          failures++;
          $display("FAIL pulse_match actual=(edge %0d ch %0d) required=(edge %0d ch %0d)",
                   cyc, o_dec, e.cyc, e.ch);
        end
      end
    end
  end

  task automatic test_reset();
    int r;
    #1;
    checks++;
    if ({o_inc, o_dec, o_held} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_initial actual=%b required=0000", {o_inc, o_dec, o_held});
    end
    wait_cyc(3);
    i_rst = 1'b0;
    wait_cyc(3);
    i_btn_inc = 1'b1;
    i_btn_dec = 1'b1;
    wait_cyc(4);
    i_rst = 1'b1;
    #1;
    checks++;
    if ({o_inc, o_dec, o_held} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_count actual=%b required=0000", {o_inc, o_dec, o_held});
    end
    @(negedge i_clk);
    i_btn_dec = 1'b0;
    wait_cyc(2);
    checks++;
    if ({o_inc, o_dec, o_held} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_held actual=%b required=0000", {o_inc, o_dec, o_held});
    end
    i_rst = 1'b0;
    r = cyc;
    push(r + LAT, 1'b0);
    wait_cyc(12);
    checks++;
    if (o_held !== 2'b01) begin
      failures++;
      $display("FAIL reset_release_held actual=%b required=01", o_held);
    end
    i_btn_inc = 1'b0;
    wait_cyc(10);
    checks++;
    if (sb.size() != 0 || o_held !== 2'b00) begin
      failures++;
      $display("FAIL reset_end actual=(pending %0d held %b) required=(0 00)", sb.size(), o_held);
    end
  endtask

  task automatic test_clean_press();
    int c;
    int t0;
    c = cyc;
    i_btn_inc = 1'b1;
    t0 = c + LAT;
    push(t0, 1'b0);
`ifdef BUTTON_REPEAT_EN
    for (int off = P_RD; off <= 105; off += P_RP) push(t0 + off, 1'b0);
`endif
    wait_cyc(5);
    checks++;
    if (o_held[0] !== 1'b0) begin
      failures++;
      $display("FAIL held_early actual=%b required=0", o_held[0]);
    end
    wait_cyc(1);
    checks++;
    if (o_held[0] !== 1'b1) begin
      failures++;
      $display("FAIL held_on_time actual=%b required=1", o_held[0]);
    end
    wait_cyc(t0 + 102 - cyc);
    i_btn_inc = 1'b0;
    wait_cyc(12);
    checks++;
    if (sb.size() != 0 || o_held !== 2'b00) begin
      failures++;
      $display("FAIL clean_end actual=(pending %0d held %b) required=(0 00)", sb.size(), o_held);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 6; i++) begin
      i_btn_dec = (i % 2 == 0);
      wait_cyc(2);
    end
    checks++;
    if (o_held !== 2'b00) begin
      failures++;
      $display("FAIL bounce_rejected actual=%b required=00", o_held);
    end
    i_btn_dec = 1'b1;
    push(cyc + LAT, 1'b1);
    wait_cyc(10);
    checks++;
    if (o_held !== 2'b10) begin
      failures++;
      $display("FAIL bounce_settled actual=%b required=10", o_held);
    end
    i_btn_dec = 1'b0;
    wait_cyc(10);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL bounce_end actual=%0d pending required=0", sb.size());
    end
  endtask

  task automatic test_lockout();
    push(cyc + LAT, 1'b0);
    i_btn_inc = 1'b1;
    wait_cyc(10);
    i_btn_dec = 1'b1;
    wait_cyc(12);
    checks++;
    if (o_held !== 2'b11) begin
      failures++;
      $display("FAIL lock_both_held actual=%b required=11", o_held);
    end
    i_btn_inc = 1'b0;
    wait_cyc(12);
    checks++;
    if (o_held !== 2'b10) begin
      failures++;
      $display("FAIL lock_dec_only actual=%b required=10", o_held);
    end
    i_btn_dec = 1'b0;
    wait_cyc(10);
    // simultaneous press: both lock, nothing pushed
    i_btn_inc = 1'b1;
    i_btn_dec = 1'b1;
    wait_cyc(12);
    checks++;
    if (o_held !== 2'b11) begin
      failures++;
      $display("FAIL simul_held actual=%b required=11", o_held);
    end
    i_btn_inc = 1'b0;
    i_btn_dec = 1'b0;
    wait_cyc(10);
    // a fresh press after release is accepted again
    push(cyc + LAT, 1'b1);
    i_btn_dec = 1'b1;
    wait_cyc(12);
    i_btn_dec = 1'b0;
    wait_cyc(10);
    checks++;
    if (sb.size() != 0 || o_held !== 2'b00) begin
      failures++;
      $display("FAIL lock_end actual=(pending %0d held %b) required=(0 00)", sb.size(), o_held);
    end
  endtask

  task automatic test_repeat();
    int t0;
    t0 = cyc + LAT;
    i_btn_inc = 1'b1;
    push(t0, 1'b0);
`ifdef BUTTON_REPEAT_EN
    push(t0 + P_RD, 1'b0);
    push(t0 + P_RD + P_RP, 1'b0);
    push(t0 + P_RD + 2 * P_RP, 1'b0);
`endif
    wait_cyc(t0 + 27 - cyc);
    i_btn_dec = 1'b1;
    wait_cyc(t0 + 60 - cyc);
    checks++;
    if (o_held !== 2'b11) begin
      failures++;
      $display("FAIL repeat_both_held actual=%b required=11", o_held);
    end
    i_btn_inc = 1'b0;
    i_btn_dec = 1'b0;
    wait_cyc(12);
    checks++;
    if (sb.size() != 0 || o_held !== 2'b00) begin
      failures++;
      $display("FAIL repeat_end actual=(pending %0d held %b) required=(0 00)", sb.size(), o_held);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_lockout();
    test_repeat();
    wait_cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
